sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Owns the external 16-bit async SRAM on clk200 and serves two requesters: the Amiga-side
//  CPU port and the SPI port driven by spi_controller's spi_req/spi_ack toggle handshake.
//  Runs one SRAM cycle at a time, returns read words, and toggles the matching ack.
//  CPU port has fixed priority because Amiga bus timing is hard real-time.
// PARAMETERS
//  ACCESS_CYCLES  3  clk200 cycles OE/WE held active (3 = 15 ns, fits 10 ns SRAM); legal 1..15
//  STARVE_LIMIT   4  consecutive CPU grants with SPI pending before SPI is forced (see CONFIGURATION)
// PORTS
//  clk200           in   1   200 MHz system clock; everything here is on it
//  reset            in   1   synchronous, active-high reset
//  spi_req          in   1   SPI request toggle (already synchronised to clk200)
//  spi_ack          out  1   SPI ack toggle; request pending while spi_req != spi_ack
//  spi_read_sram    in   1   1 = read, 0 = write (byte)
//  spi_address_sram in   20  SPI word address
//  spi_ub           in   1   1 = upper byte lane [15:8], 0 = lower [7:0]
//  spi_out_sram_in  in   8   SPI write byte
//  spi_in_sram_out  out  16  last SPI read word (held until next SPI read completes)
//  cpu_req          in   1   CPU request toggle; pending while cpu_req != cpu_ack
//  cpu_ack          out  1   CPU ack toggle
//  cpu_read         in   1   1 = read, 0 = write
//  cpu_address      in   20  CPU word address
//  cpu_ub, cpu_lb   in   1   byte-lane enables (active high)
//  cpu_data_in      in   16  CPU write word
//  cpu_data_out     out  16  last CPU read word
//  sram_a           out  20  SRAM address
//  sram_d_out       out  16  SRAM write data;  sram_d_oe out 1: drive data bus
//  sram_d_in        in   16  SRAM read data (registered at pad)
//  sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out 1 each  SRAM strobes, active low
// BEHAVIOUR
//  Reset: state IDLE; spi_ack=0, cpu_ack=0, spi_in_sram_out=0, cpu_data_out=0, sram_a=0,
//   sram_d_out=0, sram_d_oe=0, sram_oe_n=1, sram_we_n=1, sram_ub_n=1, sram_lb_n=1, starve cnt=0.
//   Reset mid-cycle aborts it in the same edge; no ack toggles; the requester retries by pending state.
//  Pending: cpu_pend = cpu_req^cpu_ack; spi_pend = spi_req^spi_ack. Evaluated in IDLE only.
//  FSM: IDLE -> ACCESS -> FINISH -> IDLE.
//   IDLE: if cpu_pend grant CPU, else if spi_pend grant SPI, else stay. On grant register
//    address, direction, lanes and write data (owner's inputs sampled this edge) and go ACCESS.
//   ACCESS: held ACCESS_CYCLES cycles (cnt 0..ACCESS_CYCLES-1). Read: sram_oe_n=0, d_oe=0.
//    Write: d_oe=1 throughout, sram_we_n=0. Lane strobes: CPU -> ~cpu_ub/~cpu_lb;
//    SPI -> only the spi_ub lane low; SPI write data = {byte,byte}.
//   FINISH (1 cycle): all strobes high, d_oe stays 1 for writes (hold); read data from
//    sram_d_in captured on the ACCESS->FINISH edge into owner's *_data_out/spi_in_sram_out;
//    owner's ack toggles on FINISH->IDLE edge, so read data is valid no later than ack.
//  Latency: pending seen in IDLE -> ack toggles ACCESS_CYCLES+2 cycles later (5 at default).
//   Back-to-back: next grant decision in the IDLE cycle after FINISH; min period ACCESS_CYCLES+2.
//  Simultaneous pending: CPU wins (unless forced, see CONFIGURATION); SPI waits, never lost.
//  A requester toggling again before its ack is a protocol error; behaviour undefined.
//  CPU request with cpu_ub=cpu_lb=0: full cycle run, no lane strobed, ack still toggles.
//  sram_a/sram_d_out hold their last value in IDLE; strobes never low in IDLE.
// CONFIGURATION
//  SRAM_ARB_STARVE_GUARD_EN defined: counter of consecutive CPU grants made while spi_pend;
//   cleared on any SPI grant or when spi_pend is 0 at a grant; when it reaches STARVE_LIMIT
//   the next IDLE with spi_pend grants SPI even if cpu_pend, then counter clears.
//  Not defined: pure fixed CPU priority, no counter logic; SPI can starve indefinitely.
// TESTING
//  1 reset asserted mid-ACCESS of CPU write -> next cycle all strobes 1, d_oe 0, acks unchanged.
//  2 SPI read addr 0x00010 ub=1, SRAM model word 0xA55A -> spi_in_sram_out=0xA55A, ub_n=0,
//    lb_n=1 in ACCESS, spi_ack toggles exactly 5 cycles after pending seen.
//  3 SPI write byte 0x3C, ub=0, addr 0x00020 -> sram_d_out=0x3C3C, only lb_n low, we_n low 3 cycles,
//    model word lower byte = 0x3C, upper unchanged.
//  4 CPU and SPI pending same cycle -> CPU served first, SPI granted in the IDLE after CPU ack.
//  5 Guard on, CPU re-requests every ack with SPI pending -> SPI granted on 5th grant;
//    guard off -> SPI not granted while CPU continuous.
//  6 CPU write ub=lb=0 -> no lane strobe low, cpu_ack still toggles after 5 cycles.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bus bundle between sram_arbiter and its environment: the CPU and SPI
// request/ack toggle ports and the external async SRAM pins.
// slave  : arbiter view (drives acks, read data and SRAM strobes)
// master : environment view (requesters plus the SRAM pad registers)
interface sram_arbiter_if;
    logic        spi_req;
    logic        spi_ack;
    logic        spi_read_sram;
    logic [19:0] spi_address_sram;
    logic        spi_ub;
    logic [7:0]  spi_out_sram_in;
    logic [15:0] spi_in_sram_out;

    logic        cpu_req;
    logic        cpu_ack;
    logic        cpu_read;
    logic [19:0] cpu_address;
    logic        cpu_ub;
    logic        cpu_lb;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_out;

    logic [19:0] sram_a;
    logic [15:0] sram_d_out;
    logic        sram_d_oe;
    logic [15:0] sram_d_in;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    modport slave (
        input  spi_req, spi_read_sram, spi_address_sram, spi_ub, spi_out_sram_in,
        input  cpu_req, cpu_read, cpu_address, cpu_ub, cpu_lb, cpu_data_in,
        input  sram_d_in,
        output spi_ack, spi_in_sram_out, cpu_ack, cpu_data_out,
        output sram_a, sram_d_out, sram_d_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport master (
        output spi_req, spi_read_sram, spi_address_sram, spi_ub, spi_out_sram_in,
        output cpu_req, cpu_read, cpu_address, cpu_ub, cpu_lb, cpu_data_in,
        output sram_d_in,
        input  spi_ack, spi_in_sram_out, cpu_ack, cpu_data_out,
        input  sram_a, sram_d_out, sram_d_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: owns the external 16-bit async SRAM on clk200 and serves the
// CPU port (fixed priority, hard real-time) and the SPI port, one SRAM cycle at
// a time: IDLE -> ACCESS (ACCESS_CYCLES clocks) -> FINISH -> IDLE.
// Requests/acks are toggles: a port is pending while req != ack.
// Optional feature macro: SRAM_ARB_STARVE_GUARD_EN -- when defined, SPI is
// forced through after STARVE_LIMIT consecutive CPU grants made while SPI was
// pending; when undefined the CPU has pure fixed priority.
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 3
`ifdef SRAM_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT  = 4
`endif
) (
    input  logic          clk200,
    input  logic          reset,
    sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_spi_q, owner_spi_d;
    logic        read_q, read_d;
    logic        spi_ack_q, spi_ack_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [15:0] spi_rdata_q, spi_rdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;

    logic        cpu_pend_s;
    logic        spi_pend_s;
    logic        force_spi_s;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;
`endif

    // Pending detection from the toggle pairs and the optional SPI override
    always_comb begin
        cpu_pend_s = bus.cpu_req ^ cpu_ack_q;
        spi_pend_s = bus.spi_req ^ spi_ack_q;
`ifdef SRAM_ARB_STARVE_GUARD_EN
        force_spi_s = spi_pend_s && (starve_q >= STARVE_W'(STARVE_LIMIT));
`else
        force_spi_s = 1'b0;
`endif
    end

    // Next-state and next-output computation for the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_spi_d = owner_spi_q;
        read_d      = read_q;
        spi_ack_d   = spi_ack_q;
        cpu_ack_d   = cpu_ack_q;
        spi_rdata_d = spi_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        addr_d      = addr_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        ub_n_d      = ub_n_q;
        lb_n_d      = lb_n_q;
`ifdef SRAM_ARB_STARVE_GUARD_EN
        starve_d    = starve_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_pend_s && !force_spi_s) begin
                    state_d     = S_ACCESS;
                    cnt_d       = 4'd0;
                    owner_spi_d = 1'b0;
                    read_d      = bus.cpu_read;
                    addr_d      = bus.cpu_address;
                    if (!bus.cpu_read) begin
                        d_out_d = bus.cpu_data_in;
                    end else begin
                        d_out_d = d_out_q;
                    end
                    d_oe_d = ~bus.cpu_read;
                    oe_n_d = ~bus.cpu_read;
                    we_n_d = bus.cpu_read;
                    ub_n_d = ~bus.cpu_ub;
                    lb_n_d = ~bus.cpu_lb;
`ifdef SRAM_ARB_STARVE_GUARD_EN
                    // Count only grants that made a pending SPI wait
                    if (spi_pend_s) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end else begin
                        starve_d = {STARVE_W{1'b0}};
                    end
`endif
                end else if (spi_pend_s) begin
                    state_d     = S_ACCESS;
                    cnt_d       = 4'd0;
                    owner_spi_d = 1'b1;
                    read_d      = bus.spi_read_sram;
                    addr_d      = bus.spi_address_sram;
                    if (!bus.spi_read_sram) begin
                        d_out_d = {bus.spi_out_sram_in, bus.spi_out_sram_in};
                    end else begin
                        d_out_d = d_out_q;
                    end
                    d_oe_d = ~bus.spi_read_sram;
                    oe_n_d = ~bus.spi_read_sram;
                    we_n_d = bus.spi_read_sram;
                    ub_n_d = ~bus.spi_ub;
                    lb_n_d = bus.spi_ub;
`ifdef SRAM_ARB_STARVE_GUARD_EN
                    starve_d = {STARVE_W{1'b0}};
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FINISH;
                    cnt_d   = 4'd0;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    // Pad-registered read word is stable by the last access clock
                    if (read_q && owner_spi_q) begin
                        spi_rdata_d = bus.sram_d_in;
                    end else if (read_q) begin
                        cpu_rdata_d = bus.sram_d_in;
                    end else begin
                        spi_rdata_d = spi_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FINISH: begin
                // Write data was held through this cycle; release the bus now
                state_d = S_IDLE;
                d_oe_d  = 1'b0;
                if (owner_spi_q) begin
                    spi_ack_d = ~spi_ack_q;
                end else begin
                    cpu_ack_d = ~cpu_ack_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                d_oe_d  = 1'b0;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                lb_n_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any cycle in flight
    always_ff @(posedge clk200) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            owner_spi_q <= 1'b0;
            read_q      <= 1'b0;
            spi_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            spi_rdata_q <= 16'h0000;
            cpu_rdata_q <= 16'h0000;
            addr_q      <= 20'h00000;
            d_out_q     <= 16'h0000;
            d_oe_q      <= 1'b0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
`ifdef SRAM_ARB_STARVE_GUARD_EN
            starve_q    <= {STARVE_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_spi_q <= owner_spi_d;
            read_q      <= read_d;
            spi_ack_q   <= spi_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            spi_rdata_q <= spi_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            addr_q      <= addr_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
`ifdef SRAM_ARB_STARVE_GUARD_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign bus.spi_ack         = spi_ack_q;
    assign bus.cpu_ack         = cpu_ack_q;
    assign bus.spi_in_sram_out = spi_rdata_q;
    assign bus.cpu_data_out    = cpu_rdata_q;
    assign bus.sram_a          = addr_q;
    assign bus.sram_d_out      = d_out_q;
    assign bus.sram_d_oe       = d_oe_q;
    assign bus.sram_oe_n       = oe_n_q;
    assign bus.sram_we_n       = we_n_q;
    assign bus.sram_ub_n       = ub_n_q;
    assign bus.sram_lb_n       = lb_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: a pad-registered SRAM device model plus a
// transaction-level reference (expected memory contents, read words, ack
// latencies and per-access strobe trace) driven by random and directed traffic.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int ACC = 3;
    localparam int LAT = ACC + 2;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int STARVE_TARGET = 10;
    localparam int EXP_SPI_AT    = 4;
    localparam int EXP_CPU_TOTAL = 5;
`else
    localparam int STARVE_TARGET = 8;
    localparam int EXP_SPI_AT    = 8;
    localparam int EXP_CPU_TOTAL = 8;
`endif

    typedef struct packed {
        logic        rd;
        logic [19:0] a;
        logic        ub;
        logic        lb;
        logic [15:0] d;
    } cpu_t;

    typedef struct packed {
        logic        rd;
        logic [19:0] a;
        logic        ub;
        logic [7:0]  b;
    } spi_t;

    logic clk200 = 1'b0;
    logic reset  = 1'b1;
    logic load_mem = 1'b0;

    sram_arbiter_if bus();
    sram_arbiter dut (.clk200(clk200), .reset(reset), .bus(bus));

    always #5 clk200 = ~clk200;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] ref_mem [0:255];
    logic [15:0] dev_mem [0:255];
    logic [15:0] exp_cpu_data = 16'h0000;
    logic [15:0] exp_spi_data = 16'h0000;
    logic [40:0] exp_trace [$];
    logic [40:0] obs_trace [$];

    // SRAM device: byte-lane writes while WE is low, read word registered at the pad
    always @(posedge clk200) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= ref_mem[i];
        end else if (!bus.sram_we_n && bus.sram_d_oe) begin
            if (!bus.sram_ub_n) dev_mem[bus.sram_a[7:0]][15:8] <= bus.sram_d_out[15:8];
            if (!bus.sram_lb_n) dev_mem[bus.sram_a[7:0]][7:0]  <= bus.sram_d_out[7:0];
        end
        bus.sram_d_in <= dev_mem[bus.sram_a[7:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] entry(input logic oe_n, input logic we_n, input logic ub_n,
                                          input logic lb_n, input logic d_oe,
                                          input logic [19:0] a, input logic [15:0] d);
        return {oe_n, we_n, ub_n, lb_n, d_oe, a, d};
    endfunction

    // Reference: one CPU transaction -> ACC strobe cycles and its effect on memory
    task automatic model_cpu(input cpu_t c);
        for (int i = 0; i < ACC; i++)
            exp_trace.push_back(entry(!c.rd, c.rd, !c.ub, !c.lb, !c.rd, c.a, c.rd ? 16'h0 : c.d));
        if (c.rd) exp_cpu_data = ref_mem[c.a[7:0]];
        else begin
            if (c.ub) ref_mem[c.a[7:0]][15:8] = c.d[15:8];
            if (c.lb) ref_mem[c.a[7:0]][7:0]  = c.d[7:0];
        end
    endtask

    // Reference: one SPI transaction; a single lane chosen by ub, byte replicated
    task automatic model_spi(input spi_t s);
        for (int i = 0; i < ACC; i++)
            exp_trace.push_back(entry(!s.rd, s.rd, !s.ub, s.ub, !s.rd, s.a, s.rd ? 16'h0 : {s.b, s.b}));
        if (s.rd) exp_spi_data = ref_mem[s.a[7:0]];
        else if (s.ub) ref_mem[s.a[7:0]][15:8] = s.b;
        else ref_mem[s.a[7:0]][7:0] = s.b;
    endtask

    task automatic drive_fields(input cpu_t c, input spi_t s);
        bus.cpu_read = c.rd; bus.cpu_address = c.a; bus.cpu_ub = c.ub;
        bus.cpu_lb = c.lb; bus.cpu_data_in = c.d;
        bus.spi_read_sram = s.rd; bus.spi_address_sram = s.a; bus.spi_ub = s.ub;
        bus.spi_out_sram_in = s.b;
    endtask

    // Issue CPU and/or SPI in the same cycle and check everything that follows
    task automatic run_pair(input bit use_cpu, input cpu_t c, input bit use_spi, input spi_t s,
                            input string tag);
        int cpu_at, spi_at, viol;
        logic cpu_ack0, spi_ack0;
        cpu_at = -1; spi_at = -1; viol = 0;
        exp_trace.delete(); obs_trace.delete();
        drive_fields(c, s);
        @(posedge clk200); #1;
        cpu_ack0 = bus.cpu_ack; spi_ack0 = bus.spi_ack;
        if (use_cpu) bus.cpu_req = ~bus.cpu_req;
        if (use_spi) bus.spi_req = ~bus.spi_req;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk200); #1;
            if (!bus.sram_oe_n || !bus.sram_we_n)
                obs_trace.push_back(entry(bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n,
                                          bus.sram_d_oe, bus.sram_a,
                                          bus.sram_we_n ? 16'h0 : bus.sram_d_out));
            else if (!bus.sram_ub_n || !bus.sram_lb_n) viol++;
            if (!bus.sram_oe_n && (bus.sram_d_oe || !bus.sram_we_n)) viol++;
            if (cpu_at < 0 && bus.cpu_ack != cpu_ack0) cpu_at = cyc;
            if (spi_at < 0 && bus.spi_ack != spi_ack0) spi_at = cyc;
            if ((!use_cpu || cpu_at >= 0) && (!use_spi || spi_at >= 0)) break;
        end
        if (use_cpu) model_cpu(c);
        if (use_spi) model_spi(s);
        chk({tag, "_cpu_lat"}, cpu_at, use_cpu ? LAT : -1);
        chk({tag, "_spi_lat"}, spi_at, use_spi ? (use_cpu ? 2 * LAT : LAT) : -1);
        chk({tag, "_strobe_viol"}, viol, 0);
        chk({tag, "_trace_len"}, obs_trace.size(), exp_trace.size());
        for (int i = 0; i < exp_trace.size() && i < obs_trace.size(); i++)
            chk($sformatf("%s_trace%0d", tag, i), obs_trace[i], exp_trace[i]);
        chk({tag, "_cpu_data"}, bus.cpu_data_out, exp_cpu_data);
        chk({tag, "_spi_data"}, bus.spi_in_sram_out, exp_spi_data);
        chk({tag, "_idle_strobes"}, {bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n,
                                     bus.sram_d_oe}, 5'b11110);
        if (use_cpu && !c.rd) chk({tag, "_cpu_mem"}, dev_mem[c.a[7:0]], ref_mem[c.a[7:0]]);
        if (use_spi && !s.rd) chk({tag, "_spi_mem"}, dev_mem[s.a[7:0]], ref_mem[s.a[7:0]]);
    endtask

    initial begin
        cpu_t c;
        spi_t s;
        int cyc_cnt, cpu_done, spi_at;
        logic cpu_prev, spi_prev, spi_seen;

        bus.cpu_req = 1'b0; bus.spi_req = 1'b0;
        c = '0; s = '0;
        drive_fields(c, s);
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
        ref_mem[8'h10] = 16'hA55A;
        ref_mem[8'h20] = 16'h7E81;
        load_mem = 1'b1;
        repeat (3) @(posedge clk200);
        #1;
        load_mem = 1'b0;

        // Reset state
        chk("rst_spi_ack", bus.spi_ack, 1'b0);
        chk("rst_cpu_ack", bus.cpu_ack, 1'b0);
        chk("rst_spi_data", bus.spi_in_sram_out, 16'h0);
        chk("rst_cpu_data", bus.cpu_data_out, 16'h0);
        chk("rst_sram_a", bus.sram_a, 20'h0);
        chk("rst_d_out", bus.sram_d_out, 16'h0);
        chk("rst_strobes", {bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n,
                            bus.sram_d_oe}, 5'b11110);
        reset = 1'b0;

        // Reset in the middle of a CPU write aborts it; the pending request retries
        c = '{rd: 1'b0, a: 20'h00055, ub: 1'b1, lb: 1'b1, d: 16'hBEEF};
        drive_fields(c, s);
        @(posedge clk200); #1;
        bus.cpu_req = ~bus.cpu_req;
        @(posedge clk200); #1;
        @(posedge clk200); #1;
        chk("midrst_we_active", bus.sram_we_n, 1'b0);
        reset = 1'b1;
        @(posedge clk200); #1;
        chk("midrst_strobes", {bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 4'hF);
        chk("midrst_d_oe", bus.sram_d_oe, 1'b0);
        chk("midrst_acks", {bus.cpu_ack, bus.spi_ack}, 2'b00);
        reset = 1'b0;
        cyc_cnt = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk200); #1;
            if (bus.cpu_ack == 1'b1) begin cyc_cnt = cyc; break; end
        end
        chk("midrst_retry_lat", cyc_cnt, LAT);
        ref_mem[8'h55] = 16'hBEEF;
        chk("midrst_retry_mem", dev_mem[8'h55], ref_mem[8'h55]);

        // Directed: SPI read upper lane, SPI byte write lower lane, CPU write no lanes
        s = '{rd: 1'b1, a: 20'h00010, ub: 1'b1, b: 8'h00};
        run_pair(1'b0, c, 1'b1, s, "spi_rd");
        chk("spi_rd_word", bus.spi_in_sram_out, 16'hA55A);
        s = '{rd: 1'b0, a: 20'h00020, ub: 1'b0, b: 8'h3C};
        run_pair(1'b0, c, 1'b1, s, "spi_wr");
        chk("spi_wr_word", dev_mem[8'h20], 16'h7E3C);
        c = '{rd: 1'b0, a: 20'h00030, ub: 1'b0, lb: 1'b0, d: 16'h1234};
        run_pair(1'b1, c, 1'b0, s, "cpu_nolane");

        // Simultaneous pending: CPU first, SPI right after
        c = '{rd: 1'b1, a: 20'h00020, ub: 1'b1, lb: 1'b1, d: 16'h0};
        s = '{rd: 1'b0, a: 20'h00020, ub: 1'b1, b: 8'hC3};
        run_pair(1'b1, c, 1'b1, s, "both");

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 2);
            c = '{rd: 1'($urandom), a: 20'($urandom), ub: 1'($urandom), lb: 1'($urandom),
                  d: 16'($urandom)};
            s = '{rd: 1'($urandom), a: 20'($urandom), ub: 1'($urandom), b: 8'($urandom)};
            run_pair(kind != 1, c, kind != 0, s, $sformatf("rnd%0d", it));
        end

        // Continuous CPU traffic while SPI waits
        c = '{rd: 1'b1, a: 20'h00010, ub: 1'b1, lb: 1'b1, d: 16'h0};
        s = '{rd: 1'b1, a: 20'h00055, ub: 1'b0, b: 8'h0};
        drive_fields(c, s);
        @(posedge clk200); #1;
        cpu_prev = bus.cpu_ack; spi_prev = bus.spi_ack;
        cpu_done = 0; spi_at = -1; spi_seen = 1'b0;
        bus.cpu_req = ~bus.cpu_req;
        bus.spi_req = ~bus.spi_req;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk200); #1;
            if (bus.cpu_ack != cpu_prev) begin
                cpu_prev = bus.cpu_ack;
                cpu_done++;
                if (!spi_seen && cpu_done < STARVE_TARGET) bus.cpu_req = ~bus.cpu_req;
            end
            if (!spi_seen && bus.spi_ack != spi_prev) begin
                spi_seen = 1'b1;
                spi_at = cpu_done;
            end
            if (spi_seen && bus.cpu_ack == bus.cpu_req) break;
        end
        chk("starve_spi_after_cpu", spi_at, EXP_SPI_AT);
        chk("starve_cpu_total", cpu_done, EXP_CPU_TOTAL);
        chk("starve_cpu_data", bus.cpu_data_out, ref_mem[8'h10]);
        chk("starve_spi_data", bus.spi_in_sram_out, ref_mem[8'h55]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
